// File: rtl/riscv_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs, memory handshake, branch
// resolution and counter clear from the pipeline, plus the hold, flush and
// freeze controls, FSM state and performance counters returned by the controller.
//   master : pipeline side (drives the *_i members, observes the *_o members)
//   slave  : hazard controller side
interface riscv_hazard_ctrl_if #(
  parameter int unsigned REGFILE_COUNT = 32,
  parameter int unsigned CNT_W         = 32
);
  localparam int unsigned RegW = $clog2(REGFILE_COUNT);

  logic [RegW-1:0]  rs1_ID_i;
  logic [RegW-1:0]  rs2_ID_i;
  logic             rs1_used_i;
  logic             rs2_used_i;
  logic [RegW-1:0]  rd_EX_i;
  logic             mem_read_EX_i;
  logic             branch_taken_EX_i;
  logic             dmem_req_MEM_i;
  logic             dmem_ready_i;
  logic             cnt_clr_i;
  logic             pc_hold_o;
  logic             ifid_hold_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             pipe_freeze_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output rs1_ID_i, rs2_ID_i, rs1_used_i, rs2_used_i, rd_EX_i, mem_read_EX_i,
           branch_taken_EX_i, dmem_req_MEM_i, dmem_ready_i, cnt_clr_i,
    input  pc_hold_o, ifid_hold_o, ifid_flush_o, idex_flush_o, pipe_freeze_o,
           state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  rs1_ID_i, rs2_ID_i, rs1_used_i, rs2_used_i, rd_EX_i, mem_read_EX_i,
           branch_taken_EX_i, dmem_req_MEM_i, dmem_ready_i, cnt_clr_i,
    output pc_hold_o, ifid_hold_o, ifid_flush_o, idex_flush_o, pipe_freeze_o,
           state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage RISC-V core.
// Generates PC / IF/ID hold, IF/ID and ID/EX flush, and a back-end freeze for
// load-use hazards, taken branches and multi-cycle data-memory waits.
// Priority: memory freeze > branch flush > load-use stall.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of riscv_hazard_ctrl_if (hazard inputs, controls,
//            FSM state, saturating stall/flush counters)
module riscv_hazard_ctrl #(
  parameter int unsigned REGFILE_COUNT = 32,
  parameter int unsigned CNT_W         = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  riscv_hazard_ctrl_if.slave bus
);
  localparam int unsigned RegW = $clog2(REGFILE_COUNT);
  localparam logic [RegW-1:0]  RegZero = '0;
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StRun          = 2'b00,
    StMemWait      = 2'b01,
    StMemWaitFlush = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             freeze, flush, lu, hold;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a branch seen while frozen is parked in StMemWaitFlush
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (bus.dmem_req_MEM_i && !bus.dmem_ready_i) begin
          state_d = bus.branch_taken_EX_i ? StMemWaitFlush : StMemWait;
        end
      end
      StMemWait: begin
        if (bus.dmem_ready_i) begin
          state_d = StRun;
        end else if (bus.branch_taken_EX_i) begin
          state_d = StMemWaitFlush;
        end
      end
      StMemWaitFlush: begin
        if (bus.dmem_ready_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Output logic (Mealy)
  always_comb begin
    freeze = ((state_q != StRun) || bus.dmem_req_MEM_i) && !bus.dmem_ready_i;
    flush  = !freeze && (bus.branch_taken_EX_i || (state_q == StMemWaitFlush));
    // A flushed ID instruction is wrong-path, so it cannot raise a load-use stall
    lu     = !freeze && !flush && bus.mem_read_EX_i && (bus.rd_EX_i != RegZero) &&
             ((bus.rs1_used_i && (bus.rs1_ID_i == bus.rd_EX_i)) ||
              (bus.rs2_used_i && (bus.rs2_ID_i == bus.rd_EX_i)));
    hold   = freeze || lu;

    bus.pipe_freeze_o = freeze;
    bus.pc_hold_o     = hold;
    bus.ifid_hold_o   = hold;
    bus.ifid_flush_o  = flush;
    bus.idex_flush_o  = flush || lu;
    bus.state_o       = state_q;
    bus.stall_cnt_o   = stall_cnt_q;
    bus.flush_cnt_o   = flush_cnt_q;
  end

  // Saturating performance counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (hold && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CntOne;
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Scoreboard bench for riscv_hazard_ctrl with 4-bit counters: each directed
// vector is applied just after a rising edge with its hand-computed response
// queued; the monitor pops and compares on every falling edge.
module tb_riscv_hazard_ctrl;
  localparam int unsigned CntW = 4;

  typedef struct packed {
    logic       pc_hold;
    logic       ifid_hold;
    logic       ifid_flush;
    logic       idex_flush;
    logic       freeze;
    logic [1:0] state;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   vec_id = 0;
  exp_t exp_q[$];
  int   id_q[$];

  riscv_hazard_ctrl_if #(.REGFILE_COUNT(32), .CNT_W(CntW)) bus ();

  riscv_hazard_ctrl #(.REGFILE_COUNT(32), .CNT_W(CntW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus its expected response
  task automatic step(input logic rst, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic req, input logic rdy,
                      input logic clr, input logic hold, input logic iflush,
                      input logic idflush, input logic frz, input logic [1:0] st,
                      input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n                 = rst;
    bus.rs1_ID_i          = rs1;
    bus.rs1_used_i        = u1;
    bus.rs2_ID_i          = rs2;
    bus.rs2_used_i        = u2;
    bus.rd_EX_i           = rd;
    bus.mem_read_EX_i     = mr;
    bus.branch_taken_EX_i = br;
    bus.dmem_req_MEM_i    = req;
    bus.dmem_ready_i      = rdy;
    bus.cnt_clr_i         = clr;
    e.pc_hold    = hold;
    e.ifid_hold  = hold;
    e.ifid_flush = iflush;
    e.idex_flush = idflush;
    e.freeze     = frz;
    e.state      = st;
    e.stall_cnt  = 4'(sc);
    e.flush_cnt  = 4'(fc);
    exp_q.push_back(e);
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic idle(input logic [1:0] st, input int sc, input int fc);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, sc, fc);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  initial begin
    exp_t act, e;
    int   id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        act.pc_hold    = bus.pc_hold_o;
        act.ifid_hold  = bus.ifid_hold_o;
        act.ifid_flush = bus.ifid_flush_o;
        act.idex_flush = bus.idex_flush_o;
        act.freeze     = bus.pipe_freeze_o;
        act.state      = bus.state_o;
        act.stall_cnt  = bus.stall_cnt_o;
        act.flush_cnt  = bus.flush_cnt_o;
        n_chk++;
        if (act !== e) begin
          n_err++;
          $display("FAIL vec%0d: got hold=%b/%b ifl=%b idfl=%b frz=%b st=%b sc=%0d fc=%0d, required hold=%b/%b ifl=%b idfl=%b frz=%b st=%b sc=%0d fc=%0d",
                   id, act.pc_hold, act.ifid_hold, act.ifid_flush, act.idex_flush,
                   act.freeze, act.state, act.stall_cnt, act.flush_cnt,
                   e.pc_hold, e.ifid_hold, e.ifid_flush, e.idex_flush, e.freeze,
                   e.state, e.stall_cnt, e.flush_cnt);
        end
      end
    end
  end

  initial begin
    bus.rs1_ID_i = '0; bus.rs2_ID_i = '0; bus.rs1_used_i = 0; bus.rs2_used_i = 0;
    bus.rd_EX_i = '0; bus.mem_read_EX_i = 0; bus.branch_taken_EX_i = 0;
    bus.dmem_req_MEM_i = 0; bus.dmem_ready_i = 0; bus.cnt_clr_i = 0;

    //   rst rs1 u1 rs2 u2 rd mr br req rdy clr | hold ifl idfl frz st sc fc
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0);  // in reset
    idle(2'b00, 0, 0);
    // Load-use on rs2, then rd=x0 and rs2 unused give nothing, then rs1 hazard
    step(1, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0,   1, 0, 1, 0, 2'b00, 0, 0);
    idle(2'b00, 1, 0);
    step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 1, 0);
    step(1, 0, 0, 5, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 1, 0);
    step(1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0,   1, 0, 1, 0, 2'b00, 1, 0);
    idle(2'b00, 2, 0);
    // Branch cancels a simultaneous load-use
    step(1, 0, 0, 5, 1, 5, 1, 1, 0, 0, 0,   0, 1, 1, 0, 2'b00, 2, 0);
    idle(2'b00, 2, 1);
    // 3-cycle memory wait then release
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 2'b00, 2, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 2'b01, 3, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 2'b01, 4, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 2'b01, 5, 1);
    idle(2'b00, 5, 1);
    // Single-cycle access
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 2'b00, 5, 1);
    // 4-cycle wait, branch in 2nd cycle, one flush at release
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 2'b00, 5, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 2'b01, 6, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 2'b10, 7, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 2'b10, 8, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0, 1, 1, 0, 2'b10, 9, 1);
    idle(2'b00, 9, 2);
    // Branch in the first frozen cycle goes straight to MEM_WAIT_FLUSH
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 2'b00, 9, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 1, 0, 2'b10, 10, 2);
    idle(2'b00, 10, 3);
    // Reset while in MEM_WAIT_FLUSH drops the pending flush
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 2'b00, 10, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 2'b10, 11, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0);
    idle(2'b00, 0, 0);
    idle(2'b00, 0, 0);
    // 20 back-to-back load-use stalls: counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, (i > 15) ? 15 : i, 0);
    end
    // Clear beats the simultaneous stall increment
    step(1, 0, 0, 5, 1, 5, 1, 0, 0, 0, 1,   1, 0, 1, 0, 2'b00, 15, 0);
    idle(2'b00, 0, 0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
